rand_num_gen_63: RTL and testbench



---
 rtl/rand_num_gen_63_pkg.sv | 25 ++
 rtl/rand_num_gen_63.sv | 33 +++
 tb/tb_rand_num_gen_63.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rand_num_gen_63_pkg.sv
// Shared constants for the 6-bit maximal-length LFSR used for apple coordinates.
package rand_num_gen_63_pkg;

  localparam int RNG_WIDTH = 6;

  // Taps for x^6 + x^5 + 1 (bit indices into the state register).
  localparam int RNG_TAP_A = 5;
  localparam int RNG_TAP_B = 4;

  // Loaded instead of an all-zero seed; zero is the LFSR's lock-up state.
  localparam logic [RNG_WIDTH-1:0] RNG_NONZERO = 6'b000001;

  // One Fibonacci step: shift left, feedback into bit 0.
  function automatic logic [RNG_WIDTH-1:0] rng_next(input logic [RNG_WIDTH-1:0] s);
    logic fb;
    fb = s[RNG_TAP_A] ^ s[RNG_TAP_B];
    return {s[RNG_WIDTH-2:0], fb};
  endfunction

  // Seed as it is actually loaded: zero is replaced so the cycle never stalls.
  function automatic logic [RNG_WIDTH-1:0] rng_safe_seed(input logic [RNG_WIDTH-1:0] seed);
    return (seed == '0) ? RNG_NONZERO : seed;
  endfunction

endpackage

// File: rtl/rand_num_gen_63.sv
// Free-running 6-bit Fibonacci LFSR (period 63, never zero).
// The output is the state register itself; seed only reaches it through
// the register on a reset edge.
module rand_num_gen_63
  import rand_num_gen_63_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RNG_WIDTH-1:0] seed,
  output logic [RNG_WIDTH-1:0] rnd
);

  // Power-up value keeps instances without a reset connection in the
  // non-zero cycle.
  logic [RNG_WIDTH-1:0] r_state = RNG_NONZERO;
  logic [RNG_WIDTH-1:0] w_next;
  logic [RNG_WIDTH-1:0] w_seed_safe;

  assign w_next      = rng_next(r_state);
  assign w_seed_safe = rng_safe_seed(seed);

  // Load the (non-zero) seed on reset, otherwise advance every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= w_seed_safe;
    end else begin
      r_state <= w_next;
    end
  end

  assign rnd = r_state;

endmodule

// File: tb/tb_rand_num_gen_63.sv
// Directed bench for rand_num_gen_63 with hand-computed expected sequences.
module tb_rand_num_gen_63;

  logic       clk;
  logic       reset;
  logic [5:0] seed;
  logic [5:0] rnd;

  int n_checks = 0;
  int n_errors = 0;

  rand_num_gen_63 dut (
    .clk   (clk),
    .reset (reset),
    .seed  (seed),
    .rnd   (rnd)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the next rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Expected values, computed by hand from fb = s[5]^s[4], next = {s[4:0], fb}.
  logic [5:0] exp_pwr   [6] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03};
  logic [5:0] exp_seq26 [6] = '{6'h26, 6'h0D, 6'h1A, 6'h35, 6'h2A, 6'h15};
  logic [5:0] exp_seq00 [6] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21};
  logic [5:0] exp_run10 [10] = '{6'h0D, 6'h1A, 6'h35, 6'h2A, 6'h15,
                                 6'h2B, 6'h17, 6'h2F, 6'h1F, 6'h3F};
  logic [63:0] seen;

  initial begin
    reset = 1'b0;
    seed  = 6'h2A;   // seed must not matter before any reset

    // Power-up, no reset: starts at 1 and walks 2, 4, 8, 0x10, 0x21, 0x03.
    #2;
    check("powerup_init", rnd, 6'h01);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("powerup_step%0d", i), rnd, exp_pwr[i]);
    end

    // Seed 0x26: one-cycle reset pulse, then free run.
    seed  = 6'h26;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("seed26_step0", rnd, exp_seq26[0]);
    for (int i = 1; i < 6; i++) begin
      step();
      check($sformatf("seed26_step%0d", i), rnd, exp_seq26[i]);
    end

    // Seed 0x29: full period, all distinct and non-zero, returns after 63.
    seed  = 6'h29;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("seed29_start", rnd, 6'h29);
    seen = '0;
    seen[rnd] = 1'b1;
    for (int i = 1; i < 63; i++) begin
      step();
      check($sformatf("seed29_nonzero%0d", i), (rnd != 6'h00) ? 6'h01 : 6'h00, 6'h01);
      check($sformatf("seed29_unique%0d", i), {5'b0, seen[rnd]}, 6'h00);
      seen[rnd] = 1'b1;
    end
    step();
    check("seed29_wrap", rnd, 6'h29);

    // Zero seed substitutes 1, then doubles upward.
    seed  = 6'h00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("seed00_step0", rnd, exp_seq00[0]);
    for (int i = 1; i < 6; i++) begin
      step();
      check($sformatf("seed00_step%0d", i), rnd, exp_seq00[i]);
    end

    // Reset held 5 cycles: value pinned to seed, then steps on release.
    seed  = 6'h26;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold_cycle%0d", i), rnd, 6'h26);
    end
    reset = 1'b0;
    step();
    check("hold_release", rnd, 6'h0D);

    // Seed change without reset has no effect; a later reset picks it up.
    for (int i = 1; i < 10; i++) begin
      step();
      check($sformatf("run10_step%0d", i), rnd, exp_run10[i]);
    end
    seed = 6'h3F;
    step();
    check("seedchg_noeffect0", rnd, 6'h3E);
    step();
    check("seedchg_noeffect1", rnd, 6'h3C);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("seedchg_reset", rnd, 6'h3F);
    step();
    check("seedchg_after", rnd, 6'h3E);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
